// File: rtl/active_list_retire.sv
// In-order retirement of the active list: frees old pregs, commits mappings. Optional ACTIVE_LIST_BYPASS_EN.
// Latency: completion to release 1 cycle (0 with ACTIVE_LIST_BYPASS_EN); commit pulse one cycle after retire.
// Backpressure: release_ready low stalls the head and every younger entry; dispatch_ready drops when full.
module active_list_retire #(
    parameter int DEPTH  = 32,
    parameter int LREG_W = 5,
    parameter int PREG_W = 6,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              dispatch_valid,
    output logic              dispatch_ready,
    input  logic              dispatch_uses_rw,
    input  logic [LREG_W-1:0] dispatch_lreg,
    input  logic [PREG_W-1:0] dispatch_new_preg,
    input  logic [PREG_W-1:0] dispatch_old_preg,
    output logic [TAG_W-1:0]  dispatch_tag,
    input  logic              complete_valid,
    input  logic [TAG_W-1:0]  complete_tag,
    output logic              release_valid,
    input  logic              release_ready,
    output logic [PREG_W-1:0] release_preg,
    output logic              commit_valid,
    output logic [LREG_W-1:0] commit_lreg,
    output logic [PREG_W-1:0] commit_preg,
    output logic [TAG_W:0]    count,
    output logic              empty
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    // Per-entry status bits (reset) and payload (no reset, qualified by valid)
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  uses_rw_q;
    logic [LREG_W-1:0] lreg_q     [DEPTH];
    logic [PREG_W-1:0] new_preg_q [DEPTH];
    logic [PREG_W-1:0] old_preg_q [DEPTH];

    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [TAG_W:0]    count_q;

    logic              head_done;
    logic              head_ok;
    logic              dispatch_fire;
    logic              retire_fire;

    // Full check looks only at the registered count, so a same-cycle retire never opens a slot early
    assign dispatch_ready = (count_q != FULL_CNT);
    assign dispatch_fire  = dispatch_valid & dispatch_ready & ~flush;
    assign dispatch_tag   = tail_q;
    assign count          = count_q;
    assign empty          = (count_q == '0);

`ifdef ACTIVE_LIST_BYPASS_EN
    // A completion aimed at the head counts immediately, saving a cycle of retire latency
    assign head_done = done_q[head_q] | (complete_valid & (complete_tag == head_q));
`else
    assign head_done = done_q[head_q];
`endif

    assign head_ok       = valid_q[head_q] & head_done & ~flush;
    assign release_valid = head_ok & uses_rw_q[head_q];
    assign release_preg  = old_preg_q[head_q];
    assign retire_fire   = head_ok & (~uses_rw_q[head_q] | release_ready);

    // Entry valid/done bits: flush wipes everything; otherwise complete, retire and dispatch update slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
        end else if (flush) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (complete_valid && (complete_tag == TAG_W'(i)) && valid_q[i]) begin
                    done_q[i] <= 1'b1;
                end
                if (retire_fire && (head_q == TAG_W'(i))) begin
                    valid_q[i] <= 1'b0;
                    done_q[i]  <= 1'b0;
                end
                if (dispatch_fire && (tail_q == TAG_W'(i))) begin
                    valid_q[i] <= 1'b1;
                    done_q[i]  <= 1'b0;
                end
            end
        end
    end

    // Payload capture at the tail on dispatch
    always_ff @(posedge clk) begin
        if (dispatch_fire) begin
            uses_rw_q[tail_q]  <= dispatch_uses_rw;
            lreg_q[tail_q]     <= dispatch_lreg;
            new_preg_q[tail_q] <= dispatch_new_preg;
            old_preg_q[tail_q] <= dispatch_old_preg;
        end
    end

    // Head/tail pointers wrap naturally at DEPTH; flush rewinds the tail onto the head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            tail_q  <= head_q;
            count_q <= '0;
        end else begin
            if (retire_fire) begin
                head_q <= head_q + 1'b1;
            end
            if (dispatch_fire) begin
                tail_q <= tail_q + 1'b1;
            end
            count_q <= count_q + {{TAG_W{1'b0}}, dispatch_fire} - {{TAG_W{1'b0}}, retire_fire};
        end
    end

    // Registered commit report; only register-writing instructions pulse commit_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_lreg  <= '0;
            commit_preg  <= '0;
        end else if (retire_fire) begin
            commit_valid <= uses_rw_q[head_q];
            commit_lreg  <= lreg_q[head_q];
            commit_preg  <= new_preg_q[head_q];
        end else begin
            commit_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_active_list_retire.sv
// Randomized and directed bench for active_list_retire with a queue-based reference model.
// Expected releases/commits go into scoreboard queues; a monitor checks them as the DUT emits them.
// All waits are fixed cycle counts so the run always ends on its own.
module tb_active_list_retire;

    localparam int DEPTH  = 32;
    localparam int LREG_W = 5;
    localparam int PREG_W = 6;
    localparam int TAG_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              dispatch_valid = 1'b0;
    logic              dispatch_ready;
    logic              dispatch_uses_rw = 1'b0;
    logic [LREG_W-1:0] dispatch_lreg = '0;
    logic [PREG_W-1:0] dispatch_new_preg = '0;
    logic [PREG_W-1:0] dispatch_old_preg = '0;
    logic [TAG_W-1:0]  dispatch_tag;
    logic              complete_valid = 1'b0;
    logic [TAG_W-1:0]  complete_tag = '0;
    logic              release_valid;
    logic              release_ready = 1'b0;
    logic [PREG_W-1:0] release_preg;
    logic              commit_valid;
    logic [LREG_W-1:0] commit_lreg;
    logic [PREG_W-1:0] commit_preg;
    logic [TAG_W:0]    count;
    logic              empty;

    always #5 clk = ~clk;

    active_list_retire #(
        .DEPTH(DEPTH), .LREG_W(LREG_W), .PREG_W(PREG_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_uses_rw(dispatch_uses_rw), .dispatch_lreg(dispatch_lreg),
        .dispatch_new_preg(dispatch_new_preg), .dispatch_old_preg(dispatch_old_preg),
        .dispatch_tag(dispatch_tag),
        .complete_valid(complete_valid), .complete_tag(complete_tag),
        .release_valid(release_valid), .release_ready(release_ready),
        .release_preg(release_preg),
        .commit_valid(commit_valid), .commit_lreg(commit_lreg), .commit_preg(commit_preg),
        .count(count), .empty(empty)
    );

    // Reference model: program-ordered list of in-flight instructions
    typedef struct {
        int tag;
        bit uses;
        int lreg;
        int np;
        int op;
        bit done;
    } ent_t;

    ent_t al[$];
    int   m_head = 0;
    int   m_tail = 0;
    int   exp_rel[$];
    int   exp_cmt[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // One cycle: drive inputs, check combinational outputs, predict the edge, advance the model
    task automatic step(input bit fl, input bit dv, input bit du, input int dl, input int dn,
                        input int dold, input bit cv, input int ct, input bit rr);
        bit hd;
        bit rel_v;
        bit ret;
        bit dfire;
        @(negedge clk);
        flush             = fl;
        dispatch_valid    = dv;
        dispatch_uses_rw  = du;
        dispatch_lreg     = LREG_W'(dl);
        dispatch_new_preg = PREG_W'(dn);
        dispatch_old_preg = PREG_W'(dold);
        complete_valid    = cv;
        complete_tag      = TAG_W'(ct);
        release_ready     = rr;
        #1;
        hd = (al.size() > 0) && al[0].done;
`ifdef ACTIVE_LIST_BYPASS_EN
        if ((al.size() > 0) && cv && (al[0].tag == ct)) hd = 1'b1;
`endif
        rel_v = !fl && hd && al[0].uses;
        ret   = !fl && hd && (!al[0].uses || rr);
        dfire = dv && (al.size() < DEPTH) && !fl;
        chk("dispatch_ready", longint'(dispatch_ready), longint'(al.size() < DEPTH));
        chk("count", longint'(count), longint'(al.size()));
        chk("empty", longint'(empty), longint'(al.size() == 0));
        chk("dispatch_tag", longint'(dispatch_tag), longint'(m_tail));
        chk("release_valid", longint'(release_valid), longint'(rel_v));
        if (ret && al[0].uses) begin
            exp_rel.push_back(al[0].op);
            exp_cmt.push_back(al[0].lreg * 256 + al[0].np);
        end
        if (fl) begin
            al.delete();
            m_tail = m_head;
        end else begin
            if (cv) begin
                foreach (al[i]) if (al[i].tag == ct) al[i].done = 1'b1;
            end
            if (ret) begin
                void'(al.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
            if (dfire) begin
                al.push_back('{m_tail, du, dl, dn, dold, 1'b0});
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic push(input bit du);
        step(0, 1, du, $urandom_range(31), $urandom_range(63), $urandom_range(63), 0, 0, 1);
    endtask

    task automatic rand_step();
        bit fl;
        bit cv;
        int ct;
        fl = ($urandom_range(99) < 3);
        cv = ($urandom_range(99) < 50);
        if ((al.size() > 0) && ($urandom_range(9) < 8)) ct = al[$urandom_range(al.size() - 1)].tag;
        else ct = $urandom_range(DEPTH - 1);
        step(fl, ($urandom_range(99) < 60), $urandom_range(1), $urandom_range(31),
             $urandom_range(63), $urandom_range(63), cv, ct, ($urandom_range(99) < 70));
    endtask

    task automatic check_reset_outputs();
        chk("rst_count", longint'(count), 0);
        chk("rst_empty", longint'(empty), 1);
        chk("rst_dispatch_ready", longint'(dispatch_ready), 1);
        chk("rst_release_valid", longint'(release_valid), 0);
        chk("rst_commit_valid", longint'(commit_valid), 0);
        chk("rst_commit_lreg", longint'(commit_lreg), 0);
        chk("rst_commit_preg", longint'(commit_preg), 0);
        chk("rst_dispatch_tag", longint'(dispatch_tag), 0);
    endtask

    // Monitor: consume scoreboard entries whenever the DUT hands off a release or commit
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (release_valid && release_ready) begin
                if (exp_rel.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL release_unexpected: got preg %0d, expected no release (t=%0t)", release_preg, $time);
                end else begin
                    chk("release_preg", longint'(release_preg), longint'(exp_rel.pop_front()));
                end
            end
            if (commit_valid) begin
                if (exp_cmt.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL commit_unexpected: got lreg %0d preg %0d, expected none (t=%0t)", commit_lreg, commit_preg, $time);
                end else begin
                    chk("commit_lreg_preg", longint'(commit_lreg) * 256 + longint'(commit_preg),
                        longint'(exp_cmt.pop_front()));
                end
            end
        end
    end

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Single instruction end to end
        step(0, 1, 1, 3, 40, 7, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(3);

        // Out-of-order completion, in-order retirement
        t0 = m_tail;
        for (int i = 0; i < 3; i++) step(0, 1, 1, i + 1, 10 + i, 20 + i, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, (t0 + 2) % DEPTH, 1);
        step(0, 0, 0, 0, 0, 0, 1, (t0 + 1) % DEPTH, 1);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 1, t0, 1);
        idle(5);

        // Fill to capacity (tags wrap), try to overfill
        for (int i = 0; i < DEPTH; i++) push(1'b1);
        push(1'b1);
        push(1'b1);

        // Head done but free list stalls for 5 cycles while dispatch keeps trying
        step(0, 0, 0, 0, 0, 0, 1, m_head, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 2, 3, 0, 0, 0);
        step(0, 1, 1, 1, 2, 3, 0, 0, 1);
        push(1'b1);
        push(1'b1);

        // Flush with a ready head: no release, list empties, tail snaps to head
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) push($urandom_range(1));
        step(0, 0, 0, 0, 0, 0, 1, m_head, 0);
        step(1, 1, 1, 9, 9, 9, 1, m_head, 1);
        push(1'b1);
        idle(2);

        // Completion of head in the cycle after its dispatch
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        push(1'b1);
        step(0, 0, 0, 0, 0, 0, 1, m_head, 1);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) rand_step();

        // Asynchronous reset mid-operation discards everything
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        flush = 1'b0;
        dispatch_valid = 1'b0;
        complete_valid = 1'b0;
        #1;
        check_reset_outputs();
        al.delete();
        exp_rel.delete();
        exp_cmt.delete();
        m_head = 0;
        m_tail = 0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 500; i++) rand_step();

        // Drain: complete everything outstanding and let it retire
        for (int i = 0; i < 2 * DEPTH + 4; i++) begin
            if (al.size() > 0) step(0, 0, 0, 0, 0, 0, 1, al[al.size() - 1].tag, 1);
            else step(0, 0, 0, 0, 0, 0, 0, 0, 1);
            if ((al.size() > 0) && !al[0].done) step(0, 0, 0, 0, 0, 0, 1, al[0].tag, 1);
        end
        idle(3);
        chk("release_queue_drained", longint'(exp_rel.size()), 0);
        chk("commit_queue_drained", longint'(exp_cmt.size()), 0);
        chk("final_count", longint'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
